fifo_rd_arbiter: RTL and testbench

- Read-side scheduler that shares one downstream consumer among NumPorts FIFO read ports, all in one read clock domain.
- Round-robin arbitration, with bursts of up to MaxBurst words per grant.
- Pops a granted FIFO by pulsing its rinc only when that FIFO is not empty and the output register can accept the word.
- Presents popped words on a registered valid/ready stream tagged with the source index.

---
 rtl/fifo_rd_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler sharing one registered valid/ready stream among NumPorts FIFOs.
// Define FIFO_RD_ARB_STRICT0_EN to give port 0 strict priority at every arbitration.
module fifo_rd_arbiter #(
  parameter int NumPorts  = 4,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4
) (
  input  logic                          rclk,
  input  logic                          rrst_n,
  input  logic [NumPorts-1:0]           rempty_i,
  input  logic [NumPorts*DataWidth-1:0] rdata_i,
  output logic [NumPorts-1:0]           rinc_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DataWidth-1:0]          m_data_o,
  output logic [$clog2(NumPorts)-1:0]   m_src_o,
  output logic                          busy_o
);

  // state | meaning
  // IDLE  | pick the next non-empty port; never pops
  // BURST | pop the granted port, up to MaxBurst words or until it drains
  typedef enum logic {IDLE, BURST} state_t;

  localparam int IdxW = $clog2(NumPorts);
  localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MaxBurst - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPorts - 1);

  state_t            state, state_nxt;
  logic [IdxW-1:0]   rr_ptr, grant, pick, grant_inc;
  logic [CntW-1:0]   burst_cnt;
  logic              pick_vld;
  logic              load;
  int unsigned       search_idx;

  // First non-empty port at or after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_vld   = 1'b0;
    search_idx = 0;
    for (int i = 0; i < NumPorts; i++) begin
      search_idx = (int'(rr_ptr) + i) % NumPorts;
      if (!pick_vld && !rempty_i[IdxW'(search_idx)]) begin
        pick_vld = 1'b1;
        pick     = IdxW'(search_idx);
      end
    end
`ifdef FIFO_RD_ARB_STRICT0_EN
    if (!rempty_i[0]) begin
      pick = '0;
    end
`endif
  end

  assign grant_inc = (grant == LastIdx) ? '0 : grant + 1'b1;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rinc_o    = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        load = !rempty_i[grant] && (!m_valid_o || m_ready_i);
        if (load && rrst_n) begin
          rinc_o[grant] = 1'b1;
        end
        // A drained port gives up the grant at once rather than stalling the others.
        if (rempty_i[grant] || (load && burst_cnt == LastCnt)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        grant     <= pick;
        burst_cnt <= '0;
      end
    end else if (state_nxt == IDLE) begin
      rr_ptr    <= grant_inc;
      burst_cnt <= '0;
    end else if (load) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_src_o   <= '0;
    end else if (load) begin
      m_valid_o <= 1'b1;
      m_data_o  <= rdata_i[int'(grant) * DataWidth +: DataWidth];
      m_src_o   <= grant;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO queues drive the DUT; a burst-level model predicts the
// output word order into a scoreboard that a separate monitor checks on every handshake.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rrst_n;
  logic [N-1:0]    rempty;
  logic [N*DW-1:0] rdata;
  logic [N-1:0]    rinc;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_src;
  logic            busy;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(.NumPorts(N), .DataWidth(DW), .MaxBurst(MB)) dut (
    .rclk      (clk),
    .rrst_n    (rrst_n),
    .rempty_i  (rempty),
    .rdata_i   (rdata),
    .rinc_o    (rinc),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_src_o   (m_src),
    .busy_o    (busy)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] fq[N][$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            hs_cnt = 0;
  int            first_hs = -1;
  int            last_hs = -1;
  int            rinc_cnt[N];
  int            model_rr = 0;
  logic [N-1:0]  rinc_s = '0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Burst-level model: each grant takes min(MB, words left) from the first
  // non-empty port at or after the round-robin pointer.
  task automatic build_expected();
    int  cnt[N];
    int  pos[N];
    int  p;
    int  n;
    bit  done;
    word_t w;
    for (int i = 0; i < N; i++) begin
      cnt[i] = fq[i].size();
      pos[i] = 0;
    end
    done = 1'b0;
    while (!done) begin
      p = -1;
`ifdef FIFO_RD_ARB_STRICT0_EN
      if (cnt[0] > 0) p = 0;
`endif
      for (int k = 0; k < N; k++) begin
        if (p < 0 && cnt[(model_rr + k) % N] > 0) p = (model_rr + k) % N;
      end
      if (p < 0) begin
        done = 1'b1;
      end else begin
        n = (cnt[p] < MB) ? cnt[p] : MB;
        for (int k = 0; k < n; k++) begin
          w.src  = 2'(p);
          w.data = fq[p][pos[p] + k];
          exp_q.push_back(w);
        end
        pos[p] += n;
        cnt[p] -= n;
        model_rr = (p + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      rempty[p] = (fq[p].size() == 0);
      rdata[p*DW +: DW] = (fq[p].size() > 0) ? fq[p][0] : '0;
    end
  endtask

  // One cycle: apply pops seen last cycle, drive inputs after the edge, sample before the next.
  task automatic step(input bit rdy, input bit rst_n);
    bit ok;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (rinc_s[p]) begin
        rinc_cnt[p]++;
        if (fq[p].size() > 0) void'(fq[p].pop_front());
      end
    end
    cyc++;
    rrst_n  = rst_n;
    m_ready = rdy;
    drive();
    #6;
    rinc_s = rinc;
    ok = $onehot0(rinc) && ((rinc & rempty) == '0) && (rinc == '0 || busy) && (rrst_n || rinc == '0);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rinc_invariant: rinc=%b rempty=%b busy=%b rst_n=%b, required at most one pop on a non-empty port while busy",
               rinc, rempty, busy, rrst_n);
    end
  endtask

  task automatic drain(input int max_cyc, input bit rand_rdy);
    int  k;
    bit  rdy;
    k = 0;
    while (!(exp_q.size() == 0 && !busy && !m_valid) && k < max_cyc) begin
      rdy = rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
      step(rdy, 1'b1);
      k++;
    end
    check("drain_in_time", int'(k < max_cyc), 1);
    for (int p = 0; p < N; p++) check("fifo_drained", fq[p].size(), 0);
    exp_q.delete();
  endtask

  task automatic load_port(input int p, input int n);
    for (int k = 0; k < n; k++) fq[p].push_back(DW'($urandom_range(0, 255)));
  endtask

  // Scoreboard monitor: samples ahead of the driver's sample point each cycle.
  initial begin
    word_t w;
    forever begin
      @(posedge clk);
      #6;
      if (rrst_n && m_valid && m_ready) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got src %0d data %h, required no word", m_src, m_data);
        end else begin
          w = exp_q.pop_front();
          if (m_src !== w.src || m_data !== w.data) begin
            fails++;
            $display("FAIL word: got src %0d data %h, required src %0d data %h", m_src, m_data, w.src, w.data);
          end
        end
      end
    end
  end

  initial begin
    int base;
    int k;
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    for (int p = 0; p < N; p++) begin
      rinc_cnt[p] = 0;
      load_port(p, 8);
    end
    drive();

    // Reset held with every port non-empty, then full round-robin at full rate.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("reset_rinc", rinc, 0);
      check("reset_valid", m_valid, 0);
      check("reset_busy", busy, 0);
    end
    model_rr = 0;
    build_expected();
    first_hs = -1;
    drain(300, 1'b0);
    check("rr_throughput_span", last_hs - first_hs, 32 + 7 - 1);
    for (int p = 0; p < N; p++) check("rr_pops_per_port", rinc_cnt[p], 8);

    // Early drain: port 1 with two words only.
    for (int p = 0; p < N; p++) rinc_cnt[p] = 0;
    load_port(1, 2);
    build_expected();
    drain(100, 1'b0);
    check("early_drain_pops_p1", rinc_cnt[1], 2);
    check("early_drain_pops_other", rinc_cnt[0] + rinc_cnt[2] + rinc_cnt[3], 0);

    // Back-pressure mid-burst; order must resume at port 2.
    for (int p = 0; p < N; p++) load_port(p, 4);
    build_expected();
    base = hs_cnt;
    k = 0;
    while (hs_cnt < base + 2 && k < 50) begin
      step(1'b1, 1'b1);
      k++;
    end
    check("bp_reach_word2", int'(hs_cnt >= base + 2), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      check("bp_valid", m_valid, 1);
      if (exp_q.size() > 0) begin
        check("bp_data_hold", m_data, exp_q[0].data);
        check("bp_src_hold", m_src, exp_q[0].src);
      end
      check("bp_no_rinc", rinc, 0);
    end
    drain(200, 1'b0);

    // Randomized contents and consumer back-pressure.
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < N; p++) load_port(p, $urandom_range(0, 7));
      build_expected();
      drain(800, 1'b1);
    end

    // Reset in the middle of a port 2 burst.
    load_port(2, 6);
    build_expected();
    base = hs_cnt;
    k = 0;
    while (hs_cnt < base + 2 && k < 50) begin
      step(1'b1, 1'b1);
      k++;
    end
    check("rst_mid_reach_word2", int'(hs_cnt >= base + 2), 1);
    step(1'b1, 1'b0);
    check("rst_mid_rinc2", rinc[2], 0);
    exp_q.delete();
    model_rr = 0;
    load_port(0, 3);
    build_expected();
    step(1'b1, 1'b1);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_first_src", (exp_q.size() > 0) ? int'(exp_q[0].src) : -1, 0);
    drain(200, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
